// File: rtl/framebuffer_port_arbiter.sv
// framebuffer_port_arbiter
//   Shares one framebuffer memory port between the video scanout reader
//   (fixed top priority) and two pixel writers. The writers are the
//   instruction-engine fill path (Wr1) and the pixel loader (Wr2).
//   Writers take turns round-robin, in bursts of at most MAX_BURST writes.
//   All memory-side outputs are registered. Read data comes back with a
//   one-cycle valid strobe READ_LATENCY cycles after the memory access.
//
//   Optional feature, controlled by the macro FB_ARB_BOUNDS_CHECK_EN:
//   out-of-range writes are still accepted but suppressed at the memory.
//   Out-of-range reads return 0 with normal timing and do not touch memory.
//
// Ports
//   i_Clock, i_Reset                  clock, async active-high reset
//   i_Rd_Req/i_Rd_Addr                video read request + address
//   o_Rd_Ready                        read accepted this cycle (comb)
//   o_Rd_DV/o_Rd_Data                 read return strobe + pixel
//   i_WrN_Req/i_WrN_Addr/i_WrN_Data   writer N request, address, pixel
//   o_WrN_Ready                       writer N accepted this cycle (comb)
//   o_Mem_*                           registered memory port
//   i_Mem_Read_Data                   memory read data
//   o_Owner                           current burst owner (0 none, 1 Wr1, 2 Wr2)
//
// Burst-owner states
//   state    | meaning
//   OWN_NONE | no writer holds a burst; next write is decided round-robin
//   OWN_WR1  | Wr1 holds a burst and keeps the port while it requests
//   OWN_WR2  | Wr2 holds a burst and keeps the port while it requests

module framebuffer_port_arbiter #(
  parameter int BITS_PER_PIXEL    = 3,
  parameter int FRAMEBUFFER_DEPTH = 640*480,
  parameter int MAX_BURST         = 16,
  parameter int READ_LATENCY      = 1
) (
  input  logic                      i_Clock,
  input  logic                      i_Reset,
  input  logic                      i_Rd_Req,
  input  logic [31:0]               i_Rd_Addr,
  output logic                      o_Rd_Ready,
  output logic                      o_Rd_DV,
  output logic [BITS_PER_PIXEL-1:0] o_Rd_Data,
  input  logic                      i_Wr1_Req,
  input  logic [31:0]               i_Wr1_Addr,
  input  logic [BITS_PER_PIXEL-1:0] i_Wr1_Data,
  output logic                      o_Wr1_Ready,
  input  logic                      i_Wr2_Req,
  input  logic [31:0]               i_Wr2_Addr,
  input  logic [BITS_PER_PIXEL-1:0] i_Wr2_Data,
  output logic                      o_Wr2_Ready,
  output logic                      o_Mem_Enable,
  output logic                      o_Mem_Write_Enable,
  output logic [31:0]               o_Mem_Addr,
  output logic [BITS_PER_PIXEL-1:0] o_Mem_Write_Data,
  input  logic [BITS_PER_PIXEL-1:0] i_Mem_Read_Data,
  output logic [1:0]                o_Owner
);

  if (MAX_BURST < 1 || MAX_BURST > 255 || READ_LATENCY < 1 || READ_LATENCY > 4 ||
      FRAMEBUFFER_DEPTH < 1 || BITS_PER_PIXEL < 1) begin : g_bad_param
    $error("framebuffer_port_arbiter: illegal parameter value");
  end

  localparam logic [7:0] MAX_BURST_W = 8'(MAX_BURST);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_WR1  = 2'd1,
    OWN_WR2  = 2'd2
  } owner_e;

  owner_e     owner_q, owner_d;
  owner_e     last_q, last_d;
  owner_e     grant;
  logic [7:0] burst_q, burst_d;
  logic [7:0] burst_next;
  logic       owner_req;
  logic       continuing;

  logic                      mem_en_q, mem_en_d;
  logic                      mem_we_q, mem_we_d;
  logic [31:0]               mem_addr_q, mem_addr_d;
  logic [BITS_PER_PIXEL-1:0] mem_wdata_q, mem_wdata_d;

  // Bit 0 marks the cycle the read sits on the memory port, and bit
  // READ_LATENCY marks the cycle its data returns.
  logic [READ_LATENCY:0] rd_vld_q;
  logic [READ_LATENCY:0] rd_oob_q;
  logic                  rd_issue_d, rd_oob_d;

  logic [31:0]               sel_addr;
  logic [BITS_PER_PIXEL-1:0] sel_data;
  logic                      wr_in_range, rd_in_range;

  assign owner_req = (owner_q == OWN_WR1 && i_Wr1_Req) ||
                     (owner_q == OWN_WR2 && i_Wr2_Req);

  // Arbitration and burst tracking. A pending read wins outright and
  // freezes the writer burst state. The exception is an owner that has
  // dropped its request, whose ownership is released.
  always_comb begin
    owner_d    = owner_q;
    last_d     = last_q;
    burst_d    = burst_q;
    grant      = OWN_NONE;
    continuing = 1'b0;
    o_Rd_Ready = 1'b0;
    if (!i_Reset) begin
      if (i_Rd_Req) begin
        o_Rd_Ready = 1'b1;
        if (!owner_req) begin
          owner_d = OWN_NONE;
          burst_d = 8'd0;
        end
      end else begin
        if (owner_req && burst_q < MAX_BURST_W) begin
          grant      = owner_q;
          continuing = 1'b1;
        end else if (last_q == OWN_WR1) begin
          if (i_Wr2_Req)      grant = OWN_WR2;
          else if (i_Wr1_Req) grant = OWN_WR1;
        end else begin
          if (i_Wr1_Req)      grant = OWN_WR1;
          else if (i_Wr2_Req) grant = OWN_WR2;
        end

        if (grant != OWN_NONE) begin
          if (burst_next == MAX_BURST_W) begin
            owner_d = OWN_NONE;
            last_d  = grant;
            burst_d = 8'd0;
          end else begin
            owner_d = grant;
            burst_d = burst_next;
          end
        end else begin
          owner_d = OWN_NONE;
          burst_d = 8'd0;
        end
      end
    end
  end

  assign burst_next  = continuing ? burst_q + 8'd1 : 8'd1;
  assign o_Wr1_Ready = (grant == OWN_WR1);
  assign o_Wr2_Ready = (grant == OWN_WR2);

  assign sel_addr = (grant == OWN_WR2) ? i_Wr2_Addr : i_Wr1_Addr;
  assign sel_data = (grant == OWN_WR2) ? i_Wr2_Data : i_Wr1_Data;

`ifdef FB_ARB_BOUNDS_CHECK_EN
  localparam logic [31:0] FB_DEPTH_W = 32'(FRAMEBUFFER_DEPTH);
  assign wr_in_range = (sel_addr  < FB_DEPTH_W);
  assign rd_in_range = (i_Rd_Addr < FB_DEPTH_W);
`else
  assign wr_in_range = 1'b1;
  assign rd_in_range = 1'b1;
`endif

  // Memory-port next state. Address and data hold on idle cycles.
  // A suppressed out-of-range access leaves the port idle.
  always_comb begin
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rd_issue_d  = 1'b0;
    rd_oob_d    = 1'b0;
    if (o_Rd_Ready) begin
      rd_issue_d = 1'b1;
      if (rd_in_range) begin
        mem_en_d   = 1'b1;
        mem_addr_d = i_Rd_Addr;
      end else begin
        rd_oob_d = 1'b1;
      end
    end else if (grant != OWN_NONE && wr_in_range) begin
      mem_en_d    = 1'b1;
      mem_we_d    = 1'b1;
      mem_addr_d  = sel_addr;
      mem_wdata_d = sel_data;
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      owner_q     <= OWN_NONE;
      last_q      <= OWN_NONE;
      burst_q     <= 8'd0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= '0;
      rd_vld_q    <= '0;
      rd_oob_q    <= '0;
    end else begin
      owner_q     <= owner_d;
      last_q      <= last_d;
      burst_q     <= burst_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rd_vld_q    <= {rd_vld_q[READ_LATENCY-1:0], rd_issue_d};
      rd_oob_q    <= {rd_oob_q[READ_LATENCY-1:0], rd_oob_d};
    end
  end

  assign o_Mem_Enable       = mem_en_q;
  assign o_Mem_Write_Enable = mem_we_q;
  assign o_Mem_Addr         = mem_addr_q;
  assign o_Mem_Write_Data   = mem_wdata_q;
  assign o_Owner            = owner_q;

  assign o_Rd_DV   = rd_vld_q[READ_LATENCY];
  assign o_Rd_Data = (rd_vld_q[READ_LATENCY] && !rd_oob_q[READ_LATENCY]) ?
                     i_Mem_Read_Data : '0;

endmodule

// File: tb/tb_framebuffer_port_arbiter.sv
module tb_framebuffer_port_arbiter;

  localparam int BPP = 3;
  localparam int MB  = 4;
  localparam int RL  = 2;
`ifdef FB_ARB_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            i_Reset;
  logic            i_Rd_Req;
  logic [31:0]     i_Rd_Addr;
  logic            o_Rd_Ready, o_Rd_DV;
  logic [BPP-1:0]  o_Rd_Data;
  logic            i_Wr1_Req, i_Wr2_Req;
  logic [31:0]     i_Wr1_Addr, i_Wr2_Addr;
  logic [BPP-1:0]  i_Wr1_Data, i_Wr2_Data;
  logic            o_Wr1_Ready, o_Wr2_Ready;
  logic            o_Mem_Enable, o_Mem_Write_Enable;
  logic [31:0]     o_Mem_Addr;
  logic [BPP-1:0]  o_Mem_Write_Data;
  logic [BPP-1:0]  i_Mem_Read_Data;
  logic [1:0]      o_Owner;

  framebuffer_port_arbiter #(
    .BITS_PER_PIXEL(BPP), .FRAMEBUFFER_DEPTH(640*480),
    .MAX_BURST(MB), .READ_LATENCY(RL)
  ) dut (
    .i_Clock(clk), .i_Reset(i_Reset),
    .i_Rd_Req(i_Rd_Req), .i_Rd_Addr(i_Rd_Addr), .o_Rd_Ready(o_Rd_Ready),
    .o_Rd_DV(o_Rd_DV), .o_Rd_Data(o_Rd_Data),
    .i_Wr1_Req(i_Wr1_Req), .i_Wr1_Addr(i_Wr1_Addr), .i_Wr1_Data(i_Wr1_Data),
    .o_Wr1_Ready(o_Wr1_Ready),
    .i_Wr2_Req(i_Wr2_Req), .i_Wr2_Addr(i_Wr2_Addr), .i_Wr2_Data(i_Wr2_Data),
    .o_Wr2_Ready(o_Wr2_Ready),
    .o_Mem_Enable(o_Mem_Enable), .o_Mem_Write_Enable(o_Mem_Write_Enable),
    .o_Mem_Addr(o_Mem_Addr), .o_Mem_Write_Data(o_Mem_Write_Data),
    .i_Mem_Read_Data(i_Mem_Read_Data), .o_Owner(o_Owner)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int unsigned    due;
    logic           we;
    logic [31:0]    addr;
    logic [BPP-1:0] data;
  } mem_t;

  typedef struct packed {
    int unsigned    due;
    logic [BPP-1:0] data;
  } rd_t;

  mem_t exp_mem[$];
  rd_t  exp_rd[$];
  mem_t mon_m;
  rd_t  mon_r;

  int unsigned cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: read data is a fixed function of the address and appears
  // RL cycles after the cycle the read is on the port.
  function automatic logic [BPP-1:0] pix(input logic [31:0] a);
    return a[2:0] ^ 3'b011;
  endfunction

  function automatic bit oob(input logic [31:0] a);
    return BOUNDS && (a >= 32'd307200);
  endfunction

  logic [BPP-1:0] p1 = '0, p2 = '0;
  always @(posedge clk) begin
    p1 <= (o_Mem_Enable && !o_Mem_Write_Enable) ? pix(o_Mem_Addr) : '0;
    p2 <= p1;
  end
  assign i_Mem_Read_Data = p2;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory port and read return monitors.
  always @(negedge clk) begin
    if (o_Mem_Enable) begin
      chk("mem_access_expected", exp_mem.size() > 0, 1'b1);
      if (exp_mem.size() > 0) begin
        mon_m = exp_mem.pop_front();
        chk("mem_cycle", cyc, mon_m.due);
        chk("mem_we", o_Mem_Write_Enable, mon_m.we);
        chk("mem_addr", o_Mem_Addr, mon_m.addr);
        if (mon_m.we) chk("mem_wdata", o_Mem_Write_Data, mon_m.data);
      end
    end else begin
      chk("mem_we_idle", o_Mem_Write_Enable, 1'b0);
    end
    if (o_Rd_DV) begin
      chk("rd_dv_expected", exp_rd.size() > 0, 1'b1);
      if (exp_rd.size() > 0) begin
        mon_r = exp_rd.pop_front();
        chk("rd_dv_cycle", cyc, mon_r.due);
        chk("rd_data", o_Rd_Data, mon_r.data);
      end
    end
  end

  // One arbitration cycle: check the expected Ready pattern, record the
  // accesses that must follow, then advance past the rising edge.
  task automatic tick(input bit er, input bit e1, input bit e2, input bit sb);
    @(negedge clk);
    chk("rd_ready", o_Rd_Ready, er);
    chk("wr1_ready", o_Wr1_Ready, e1);
    chk("wr2_ready", o_Wr2_Ready, e2);
    if (sb) begin
      if (er) begin
        exp_rd.push_back('{due: cyc + 1 + RL, data: oob(i_Rd_Addr) ? 3'b000 : pix(i_Rd_Addr)});
        if (!oob(i_Rd_Addr))
          exp_mem.push_back('{due: cyc + 1, we: 1'b0, addr: i_Rd_Addr, data: 3'b000});
      end
      if (e1 && !oob(i_Wr1_Addr))
        exp_mem.push_back('{due: cyc + 1, we: 1'b1, addr: i_Wr1_Addr, data: i_Wr1_Data});
      if (e2 && !oob(i_Wr2_Addr))
        exp_mem.push_back('{due: cyc + 1, we: 1'b1, addr: i_Wr2_Addr, data: i_Wr2_Data});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2 i_Reset = 1'b1;
    @(posedge clk);
    #1 i_Reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    i_Reset = 1'b1;
    i_Rd_Req = 1'b0;  i_Rd_Addr = '0;
    i_Wr1_Req = 1'b0; i_Wr1_Addr = '0; i_Wr1_Data = '0;
    i_Wr2_Req = 1'b0; i_Wr2_Addr = '0; i_Wr2_Data = '0;
    #3;
    chk("reset_outputs", {o_Mem_Enable, o_Mem_Write_Enable, o_Mem_Addr, o_Mem_Write_Data,
                          o_Rd_DV, o_Rd_Data, o_Owner}, '0);
    @(posedge clk);
    #1 i_Reset = 1'b0;
    tick(0, 0, 0, 1);

    // Wr1 alone: five writes, burst of 4 then an immediate new burst.
    i_Wr1_Req = 1'b1; i_Wr1_Data = 3'b100;
    for (int i = 0; i < 5; i++) begin
      i_Wr1_Addr = i;
      tick(0, 1, 0, 1);
      chk("t1_owner", o_Owner, (i == 3) ? 2'd0 : 2'd1);
    end
    i_Wr1_Req = 1'b0;
    tick(0, 0, 0, 1);
    chk("t1_owner_release", o_Owner, 2'd0);
    tick(0, 0, 0, 1);

    // Both writers continuous: runs of MB alternating.
    do_reset();
    i_Wr1_Req = 1'b1; i_Wr1_Addr = 32'd1000; i_Wr1_Data = 3'd1;
    i_Wr2_Req = 1'b1; i_Wr2_Addr = 32'd2000; i_Wr2_Data = 3'd6;
    for (int j = 0; j < 12; j++) begin
      bit g1;
      g1 = ((j / MB) % 2) == 0;
      tick(0, g1, !g1, 1);
      chk("t2_owner", o_Owner, (j % MB == MB - 1) ? 2'd0 : (g1 ? 2'd1 : 2'd2));
      if (g1) begin i_Wr1_Addr++; i_Wr1_Data++; end
      else    begin i_Wr2_Addr++; i_Wr2_Data++; end
    end
    i_Wr1_Req = 1'b0; i_Wr2_Req = 1'b0;
    tick(0, 0, 0, 1);

    // Read pre-empts Wr1 mid-burst; burst count and owner are held.
    do_reset();
    i_Wr1_Req = 1'b1; i_Wr1_Data = 3'd5; i_Wr1_Addr = 32'd10;
    tick(0, 1, 0, 1);
    i_Wr1_Addr = 32'd11;
    tick(0, 1, 0, 1);
    i_Wr1_Addr = 32'd12;
    i_Rd_Req = 1'b1; i_Rd_Addr = 32'd100;
    tick(1, 0, 0, 1);
    chk("t3_owner_held", o_Owner, 2'd1);
    i_Rd_Req = 1'b0;
    tick(0, 1, 0, 1);
    chk("t3_owner_resume", o_Owner, 2'd1);
    i_Wr1_Addr = 32'd13;
    tick(0, 1, 0, 1);
    chk("t3_burst_end", o_Owner, 2'd0);
    i_Wr1_Req = 1'b0;
    repeat (4) tick(0, 0, 0, 1);

    // Three back-to-back reads.
    for (int a = 7; a <= 9; a++) begin
      i_Rd_Req = 1'b1; i_Rd_Addr = a;
      tick(1, 0, 0, 1);
    end
    i_Rd_Req = 1'b0;
    repeat (5) tick(0, 0, 0, 1);

    // Asynchronous reset with a read in flight: nothing may come back.
    i_Wr1_Req = 1'b1; i_Wr1_Addr = 32'd50; i_Wr1_Data = 3'd2;
    tick(0, 1, 0, 1);
    i_Rd_Req = 1'b1; i_Rd_Addr = 32'd33;
    tick(1, 0, 0, 0);
    chk("t5_owner_before", o_Owner, 2'd1);
    i_Rd_Req = 1'b0;
    #2 i_Reset = 1'b1;
    #1;
    chk("t5_reset_outputs", {o_Mem_Enable, o_Mem_Write_Enable, o_Mem_Addr, o_Mem_Write_Data,
                             o_Rd_DV, o_Rd_Data, o_Owner, o_Rd_Ready, o_Wr1_Ready, o_Wr2_Ready}, '0);
    i_Wr1_Req = 1'b0;
    @(posedge clk);
    #1 i_Reset = 1'b0;
    repeat (6) tick(0, 0, 0, 1);
    chk("t5_owner_after", o_Owner, 2'd0);

    // Framebuffer boundary: last valid and first invalid address.
    i_Wr2_Req = 1'b1; i_Wr2_Addr = 32'd307200; i_Wr2_Data = 3'd7;
    tick(0, 0, 1, 1);
    i_Wr2_Addr = 32'd307199; i_Wr2_Data = 3'd3;
    tick(0, 0, 1, 1);
    i_Wr2_Req = 1'b0;
    i_Rd_Req = 1'b1; i_Rd_Addr = 32'd307200;
    tick(1, 0, 0, 1);
    i_Rd_Req = 1'b0;
    repeat (5) tick(0, 0, 0, 1);

    chk("mem_queue_drained", exp_mem.size(), 0);
    chk("rd_queue_drained", exp_rd.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
